// File: rtl/riscv_pkg.sv
// Shared RV32M encodings and state type for the execute-stage multiply/divide unit.
package riscv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shifts the next dividend bit into the remainder and
// subtracts the divisor when it fits; combinational, no backpressure.
module md_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;
  logic          fits;

  // rem_i < divisor, so trial < 2*divisor and the top bit of diff is a pure borrow.
  assign trial = {rem_i, quo_i[XLEN-1]};
  assign diff  = trial - {1'b0, divisor_i};
  assign fits  = ~diff[XLEN];

  assign rem_o = fits ? diff[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], fits};

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M iterative multiply/divide: XLEN+1 cycles per op, 1 cycle for divide special cases
// (and for multiplies when FAST_MUL_EN is defined); stall_o holds upstream until result_valid_o.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  md_state_e       state_q, state_d;
  md_op_e          op_q;
  logic            sa_q, sb_q;
  logic [XLEN-1:0] a_q, b_q, hi_q, lo_q, result_q;
  logic [CW-1:0]   cnt_q;

  md_op_e          op_i;
  logic            is_div_i, sa_i, sb_i, div_zero, div_ovf, special, fast, accept, last;
  logic [XLEN-1:0] abs_a, abs_b, special_res, fast_res, calc_res;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_n, mul_lo_n, div_rem_n, div_quo_n, step_hi, step_lo;

  // Turns unsigned magnitudes {hi,lo} back into the architectural result for op.
  function automatic logic [XLEN-1:0] fixup(input md_op_e op, input logic sa, input logic sb,
                                             input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] prod;
    prod = {hi, lo};
    if (sa ^ sb) prod = -prod;
    case (op)
      MD_MUL:           fixup = prod[XLEN-1:0];
      MD_DIV, MD_DIVU:  fixup = (sa ^ sb) ? -lo : lo;
      MD_REM, MD_REMU:  fixup = sa ? -hi : hi;
      default:          fixup = prod[2*XLEN-1:XLEN];
    endcase
  endfunction

  assign op_i     = md_op_e'(funct3_i);
  assign is_div_i = funct3_i[2];
  assign sa_i     = op_a_i[XLEN-1] & (op_i inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
  assign sb_i     = op_b_i[XLEN-1] & (op_i inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
  assign abs_a    = sa_i ? -op_a_i : op_a_i;
  assign abs_b    = sb_i ? -op_b_i : op_b_i;

  assign div_zero = is_div_i && (op_b_i == '0);
  assign div_ovf  = (op_i inside {MD_DIV, MD_REM}) && (op_a_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (op_b_i == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = funct3_i[1] ? op_a_i : '1;
    else if (div_ovf) special_res = funct3_i[1] ? '0 : op_a_i;
  end

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
  assign fast      = !is_div_i;
  assign fast_res  = fixup(op_i, sa_i, sb_i, fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
`else
  assign fast      = 1'b0;
  assign fast_res  = '0;
`endif

  assign accept = (state_q == IDLE) && md_valid_i && !flush_i;
  assign last   = (cnt_q == CW'(XLEN-1));

  // Multiply: lo_q holds the remaining multiplier bits and receives product low bits.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign mul_hi_n = mul_sum[XLEN:1];
  assign mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};

  md_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (hi_q),
    .quo_i     (lo_q),
    .divisor_i (b_q),
    .rem_o     (div_rem_n),
    .quo_o     (div_quo_n)
  );

  assign step_hi  = op_q[2] ? div_rem_n : mul_hi_n;
  assign step_lo  = op_q[2] ? div_quo_n : mul_lo_n;
  assign calc_res = fixup(op_q, sa_q, sb_q, step_hi, step_lo);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (special || fast) ? DONE : CALC;
      CALC:    if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    result_valid_o = (state_q == DONE);
    stall_o        = md_valid_i && !result_valid_o;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q <= MD_MUL; sa_q <= 1'b0; sb_q <= 1'b0; cnt_q <= '0;
      a_q <= '0; b_q <= '0; hi_q <= '0; lo_q <= '0; result_q <= '0;
    end else if (accept) begin
      op_q  <= op_i;
      sa_q  <= sa_i;
      sb_q  <= sb_i;
      cnt_q <= '0;
      a_q   <= abs_a;
      b_q   <= abs_b;
      hi_q  <= '0;
      lo_q  <= is_div_i ? abs_a : abs_b;
      if (special)   result_q <= special_res;
      else if (fast) result_q <= fast_res;
    end else if (state_q == CALC && !flush_i) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q + 1'b1;
      if (last) result_q <= calc_res;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized and directed checks of ex_muldiv_unit against a plain-arithmetic RV32M model.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        md_valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        stall_o;
  logic        result_valid_o;
  logic [31:0] result_o;

  int n_chk = 0;
  int n_err = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .md_valid_i     (md_valid_i),
    .funct3_i       (funct3_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, sq;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin sq = sa / sb; r = sq[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin sq = sa % sb; r = sq[31:0]; end
      end
      default: r = (b == 0) ? a : 32'(ua % ub);
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // Issues one op and follows it to its result; drop_at>0 releases md_valid_i mid-op.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int drop_at);
    int  cyc;
    int  stalls;
    bit  got;
    @(negedge clk);
    md_valid_i = 1'b1; funct3_i = f; op_a_i = a; op_b_i = b;
    #1;
    chk("stall_at_issue", {31'b0, stall_o}, 32'd1);
    stalls = stall_o ? 1 : 0;
    cyc = 0; got = 0;
    while (!got && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (result_valid_o) got = 1;
      else if (stall_o) stalls++;
      if (drop_at > 0 && cyc == drop_at) md_valid_i = 1'b0;
    end
    if (!got) chk("result_timeout", 32'd0, 32'd1);
    else begin
      chk($sformatf("res f=%0d a=%h b=%h", f, a, b), result_o, exp);
      chk("latency", 32'(cyc), 32'(ref_lat(f, a, b)));
      if (drop_at == 0) begin
        chk("stall_cycles", 32'(stalls), 32'(ref_lat(f, a, b)));
        chk("stall_low_on_done", {31'b0, stall_o}, 32'd0);
      end
    end
    @(negedge clk);
    md_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("valid_pulse_one_cycle", {31'b0, result_valid_o}, 32'd0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir[] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000},
    '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
    '{3'd5, 32'd100,        32'd7,         32'd14},
    '{3'd7, 32'd100,        32'd7,         32'd2},
    '{3'd4, 32'd1234,       32'd0,         32'hFFFF_FFFF},
    '{3'd6, 32'd5,          32'd0,         32'd5},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000},
    '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'd0, 32'd6,          32'd7,         32'd42}
  };

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    bit          saw_valid;

    rst = 1'b0; md_valid_i = 1'b0; funct3_i = 3'd0; op_a_i = '0; op_b_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'b0, result_valid_o}, 32'd0);
    chk("reset_stall", {31'b0, stall_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (dir[i]) run_op(dir[i].f, dir[i].a, dir[i].b, dir[i].exp, 0);

    // md_valid_i released during iteration still produces the result.
    run_op(3'd5, 32'd1000, 32'd33, 32'd30, 5);

    // Flush ten cycles into an iterative divide.
    @(negedge clk);
    md_valid_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd999; op_b_i = 32'd10;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1; md_valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    saw_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid_o) saw_valid = 1;
    end
    chk("flush_no_valid", {31'b0, saw_valid}, 32'd0);
    chk("flush_stall_low", {31'b0, stall_o}, 32'd0);
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0);

    // Reset in the middle of an iterative multiply.
    @(negedge clk);
    md_valid_i = 1'b1; funct3_i = 3'd0; op_a_i = 32'd5; op_b_i = 32'd9;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; md_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_valid", {31'b0, result_valid_o}, 32'd0);
    chk("midrst_stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_valid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (result_valid_o) saw_valid = 1;
    end
    chk("midrst_no_valid", {31'b0, saw_valid}, 32'd0);

    for (int k = 0; k < 40; k++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op(f, a, b, ref_md(f, a, b), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
